// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for the shared ALU: request and response channels of both ports,
// with bit/element 0 for the execute stage and 1 for the branch/address unit.
interface alu_share_arbiter_if;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][4:0]   req_op;
    logic [1:0][31:0]  req_a;
    logic [1:0][31:0]  req_b;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [1:0][31:0]  resp_result;
    logic [1:0]        resp_zero;
    logic [1:0]        resp_less;
    logic [1:0]        resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero, resp_less, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero, resp_less, resp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational RV32I ALU between two requesters,
// with a one-entry registered response buffer per requester.
module alu_share_resp_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        grant_i,
    input  logic        illegal_i,
    input  logic        ready_i,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    input  logic        alu_less_i,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        less_o,
    output logic        err_o
);
    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        less_q, less_d;
    logic        err_q, err_d;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        less_d   = less_q;
        err_d    = err_q;
        // A grant wins over a pop, so a same-cycle pop+grant refills without a bubble.
        if (grant_i) begin
            valid_d  = 1'b1;
            result_d = illegal_i ? 32'd0 : alu_result_i;
            zero_d   = illegal_i ? 1'b1  : alu_zero_i;
            less_d   = illegal_i ? 1'b0  : alu_less_i;
            err_d    = illegal_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= 32'd0;
            zero_q   <= 1'b0;
            less_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            less_q   <= less_d;
            err_q    <= err_d;
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign less_o   = less_q;
    assign err_o    = err_q;
endmodule

module alu_share_arbiter (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus,
    output logic [31:0]          alu_rs1,
    output logic [31:0]          alu_rs2,
    output logic [4:0]           alu_ctr,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_less
);
    logic [1:0]       elig;
    logic [1:0]       grant_raw;
    logic [1:0]       grant;
    logic             win;
    logic             illegal;
    logic             rr_ptr_q, rr_ptr_d;
    logic [1:0]       valid_w;
    logic [1:0][31:0] result_w;
    logic [1:0]       zero_w, less_w, err_w;

    // A full buffer being popped this cycle can take a new result, so a port's
    // eligibility (and hence the other port's grant) follows that pop.
    assign elig = bus.req_valid & (~valid_w | bus.resp_ready);

    always_comb begin
        grant_raw = elig;
        if (elig == 2'b11) begin
            grant_raw = rr_ptr_q ? 2'b10 : 2'b01;
        end
        grant = grant_raw & {2{rst_n}};

        rr_ptr_d = rr_ptr_q;
        if (grant[0])      rr_ptr_d = 1'b1;
        else if (grant[1]) rr_ptr_d = 1'b0;
    end

    assign win = grant[1];

    always_comb begin
        alu_rs1 = 32'd0;
        alu_rs2 = 32'd0;
        alu_ctr = 5'd0;
        if (|grant) begin
            alu_rs1 = bus.req_a[win];
            alu_rs2 = bus.req_b[win];
            alu_ctr = bus.req_op[win];
        end
    end

    // Holes in the ALUctr map: 0x10 and everything from 0x14 up.
    assign illegal = (alu_ctr == 5'h10) || (alu_ctr >= 5'h14);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= 1'b0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        alu_share_resp_buf u_buf (
            .clk          (clk),
            .rst_n        (rst_n),
            .grant_i      (grant[g]),
            .illegal_i    (illegal),
            .ready_i      (bus.resp_ready[g]),
            .alu_result_i (alu_result),
            .alu_zero_i   (alu_zero),
            .alu_less_i   (alu_less),
            .valid_o      (valid_w[g]),
            .result_o     (result_w[g]),
            .zero_o       (zero_w[g]),
            .less_o       (less_w[g]),
            .err_o        (err_w[g])
        );
    end

    assign bus.req_ready   = grant;
    assign bus.resp_valid  = valid_w;
    assign bus.resp_result = result_w;
    assign bus.resp_zero   = zero_w;
    assign bus.resp_less   = less_w;
    assign bus.resp_err    = err_w;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: stub RV32I ALU, per-port response scoreboard, scenario tasks.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if bus ();
    logic [31:0] alu_rs1, alu_rs2, alu_result;
    logic [4:0]  alu_ctr;
    logic        alu_zero, alu_less;

    alu_share_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_ctr    (alu_ctr),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_less   (alu_less)
    );

    int checks = 0;
    int failures = 0;

    typedef logic [34:0] exp_t;  // {err, less, zero, result}
    exp_t sb0[$];
    exp_t sb1[$];

    // Stub ALU; illegal codes yield junk so the arbiter's masking is visible.
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] imm;
        logic [4:0]  sh;
        imm = {{20{b[11]}}, b[11:0]};
        sh  = b[4:0];
        case (op)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a << sh;
            5'h03: return {31'd0, $signed(a) < $signed(b)};
            5'h04: return {31'd0, a < b};
            5'h05: return a ^ b;
            5'h06: return a >> sh;
            5'h07: return 32'($signed(a) >>> sh);
            5'h08: return a | b;
            5'h09: return a & b;
            5'h0A: return a + imm;
            5'h0B: return {31'd0, $signed(a) < $signed(imm)};
            5'h0C: return {31'd0, a < imm};
            5'h0D: return a ^ imm;
            5'h0E: return a | imm;
            5'h0F: return a & imm;
            5'h11: return a << sh;
            5'h12: return a >> sh;
            5'h13: return 32'($signed(a) >>> sh);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic exp_t exp_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (op == 5'h10 || op >= 5'h14) return {1'b1, 1'b0, 1'b1, 32'd0};
        r = alu_fn(op, a, b);
        return {1'b0, r[31], (r == 32'd0), r};
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_ctr, alu_rs1, alu_rs2);
        alu_zero   = (alu_result == 32'd0);
        alu_less   = alu_result[31];
    end

    always @(negedge rst_n) begin
        sb0.delete();
        sb1.delete();
    end

    // Scoreboard: pop-and-compare on consumption, push on acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                exp_t e, got;
                if (bus.resp_valid[p] && bus.resp_ready[p]) begin
                    got = {bus.resp_err[p], bus.resp_less[p], bus.resp_zero[p], bus.resp_result[p]};
                    checks++;
                    if ((p == 0 ? sb0.size() : sb1.size()) == 0) begin
                        failures++;
                        $display("FAIL sb_port%0d unexpected response got=%h expected=none", p, got);
                    end else begin
                        e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
                        if (got !== e) begin
                            failures++;
                            $display("FAIL sb_port%0d got=%h expected=%h", p, got, e);
                        end
                    end
                end
                if (bus.req_valid[p] && bus.req_ready[p]) begin
                    e = exp_of(bus.req_op[p], bus.req_a[p], bus.req_b[p]);
                    if (p == 0) sb0.push_back(e);
                    else        sb1.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b11;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid  = 2'b11;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 2'b00;
        tick();
        tick();
        checks++;
        if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b expected=00", bus.req_ready); end
        checks++;
        if (bus.resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b expected=00", bus.resp_valid); end
        checks++;
        if (bus.resp_result !== 64'd0) begin failures++; $display("FAIL reset_resp_result got=%h expected=0", bus.resp_result); end
        checks++;
        if ({bus.resp_zero, bus.resp_less, bus.resp_err} !== 6'd0) begin
            failures++; $display("FAIL reset_flags got=%b expected=000000", {bus.resp_zero, bus.resp_less, bus.resp_err});
        end
        checks++;
        if ({alu_rs1, alu_rs2, alu_ctr} !== 69'd0) begin failures++; $display("FAIL reset_alu_drive got=%h expected=0", {alu_rs1, alu_rs2, alu_ctr}); end
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        idle();
        bus.req_valid[0] = 1'b1; bus.req_op[0] = 5'h00; bus.req_a[0] = 32'd5; bus.req_b[0] = 32'd3;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL add_ready got=%b expected=01", bus.req_ready); end
        checks++;
        if ({alu_rs1, alu_rs2, alu_ctr} !== {32'd5, 32'd3, 5'h00}) begin
            failures++; $display("FAIL add_alu_drive got=%h/%h/%h expected=5/3/0", alu_rs1, alu_rs2, alu_ctr);
        end
        tick();
        bus.req_valid = 2'b00;
        #1;
        checks++;
        if ({bus.resp_valid[0], bus.resp_err[0], bus.resp_less[0], bus.resp_zero[0], bus.resp_result[0]} !== {4'b1000, 32'd8}) begin
            failures++; $display("FAIL add_resp got v=%b e=%b l=%b z=%b r=%h expected v=1 e=0 l=0 z=0 r=8",
                bus.resp_valid[0], bus.resp_err[0], bus.resp_less[0], bus.resp_zero[0], bus.resp_result[0]);
        end
        checks++;
        if ({bus.req_ready, alu_rs1, alu_rs2, alu_ctr} !== 71'd0) begin
            failures++; $display("FAIL idle_alu_drive got=%b/%h/%h/%h expected=0", bus.req_ready, alu_rs1, alu_rs2, alu_ctr);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.resp_ready = 2'b11;
        bus.req_op[0] = 5'h00; bus.req_a[0] = 32'd1; bus.req_b[0] = 32'd2;
        bus.req_op[1] = 5'h01; bus.req_a[1] = 32'd3; bus.req_b[1] = 32'd5;
        bus.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL contention_k%0d got=%b expected=%b", k, bus.req_ready, exp_rdy); end
            if (k == 2) begin
                checks++;
                if ({bus.resp_valid[1], bus.resp_less[1], bus.resp_result[1]} !== {2'b11, 32'hFFFF_FFFE}) begin
                    failures++; $display("FAIL contention_sub got v=%b l=%b r=%h expected v=1 l=1 r=fffffffe",
                        bus.resp_valid[1], bus.resp_less[1], bus.resp_result[1]);
                end
            end
            tick();
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        idle();
        bus.resp_ready = 2'b10;
        bus.req_valid  = 2'b01;
        bus.req_op[0] = 5'h00; bus.req_a[0] = 32'd100; bus.req_b[0] = 32'd1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL bp_first got=%b expected=01", bus.req_ready); end
        tick();
        bus.req_a[0] = 32'd200;
        bus.req_op[1] = 5'h05; bus.req_a[1] = 32'd7; bus.req_b[1] = 32'd8;
        bus.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL bp_blocked_k%0d got=%b expected=10", k, bus.req_ready); end
            checks++;
            if ({bus.resp_valid[0], bus.resp_result[0]} !== {1'b1, 32'd101}) begin
                failures++; $display("FAIL bp_hold_k%0d got v=%b r=%h expected v=1 r=65", k, bus.resp_valid[0], bus.resp_result[0]);
            end
            tick();
        end
        bus.resp_ready = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL bp_refill got=%b expected=01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        #1;
        checks++;
        if ({bus.resp_valid[0], bus.resp_result[0]} !== {1'b1, 32'd201}) begin
            failures++; $display("FAIL bp_new got v=%b r=%h expected v=1 r=c9", bus.resp_valid[0], bus.resp_result[0]);
        end
    endtask

    task automatic test_illegal();
        logic [4:0] ops  [5] = '{5'h0F, 5'h10, 5'h11, 5'h14, 5'h1F};
        logic       errs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        idle();
        bus.req_valid = 2'b01;
        bus.req_op[0] = 5'h10; bus.req_a[0] = 32'd7; bus.req_b[0] = 32'd1;
        tick();
        bus.req_op[0] = 5'h13; bus.req_a[0] = 32'h8000_0000; bus.req_b[0] = 32'd4;
        #1;
        checks++;
        if ({bus.resp_err[0], bus.resp_less[0], bus.resp_zero[0], bus.resp_result[0]} !== {3'b101, 32'd0}) begin
            failures++; $display("FAIL illegal_10 got e=%b l=%b z=%b r=%h expected e=1 l=0 z=1 r=0",
                bus.resp_err[0], bus.resp_less[0], bus.resp_zero[0], bus.resp_result[0]);
        end
        tick();
        checks++;
        if ({bus.resp_err[0], bus.resp_less[0], bus.resp_zero[0], bus.resp_result[0]} !== {3'b010, 32'hF800_0000}) begin
            failures++; $display("FAIL srai got e=%b l=%b z=%b r=%h expected e=0 l=1 z=0 r=f8000000",
                bus.resp_err[0], bus.resp_less[0], bus.resp_zero[0], bus.resp_result[0]);
        end
        for (int k = 0; k < 5; k++) begin
            bus.req_op[0] = ops[k]; bus.req_a[0] = 32'h1234_5678; bus.req_b[0] = 32'd3;
            tick();
            checks++;
            if (bus.resp_err[0] !== errs[k]) begin
                failures++; $display("FAIL err_op%h got=%b expected=%b", ops[k], bus.resp_err[0], errs[k]);
            end
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_imm();
        idle();
        bus.req_valid = 2'b01;
        bus.req_op[0] = 5'h0A; bus.req_a[0] = 32'd10; bus.req_b[0] = 32'h0000_0FFF;
        tick();
        bus.req_op[0] = 5'h0C; bus.req_a[0] = 32'd1; bus.req_b[0] = 32'h0000_0FFF;
        #1;
        checks++;
        if ({bus.resp_err[0], bus.resp_result[0]} !== {1'b0, 32'd9}) begin
            failures++; $display("FAIL addi got e=%b r=%h expected e=0 r=9", bus.resp_err[0], bus.resp_result[0]);
        end
        tick();
        bus.req_valid = 2'b00;
        checks++;
        if ({bus.resp_err[0], bus.resp_result[0]} !== {1'b0, 32'd1}) begin
            failures++; $display("FAIL sltiu got e=%b r=%h expected e=0 r=1", bus.resp_err[0], bus.resp_result[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] elig;
        idle();
        for (int k = 0; k < 24; k++) begin
            for (int p = 0; p < 2; p++) begin
                bus.req_op[p] = 5'($urandom_range(0, 31));
                bus.req_a[p]  = $urandom;
                bus.req_b[p]  = $urandom;
            end
            bus.req_valid  = 2'($urandom_range(0, 3));
            bus.resp_ready = 2'($urandom_range(0, 3));
            #1;
            elig = bus.req_valid & (~bus.resp_valid | bus.resp_ready);
            checks++;
            if (bus.req_ready == 2'b11 || (bus.req_ready & ~elig) != 2'b00 || ((elig != 2'b00) != (bus.req_ready != 2'b00))) begin
                failures++; $display("FAIL b2b_grant_k%0d got=%b eligible=%b", k, bus.req_ready, elig);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.resp_ready = 2'b00;
        bus.req_valid  = 2'b10;
        bus.req_op[1] = 5'h00; bus.req_a[1] = 32'd2; bus.req_b[1] = 32'd2;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL rstmid_grant got=%b expected=10", bus.req_ready); end
        tick();
        checks++;
        if ({bus.resp_valid[1], bus.resp_result[1]} !== {1'b1, 32'd4}) begin
            failures++; $display("FAIL rstmid_filled got v=%b r=%h expected v=1 r=4", bus.resp_valid[1], bus.resp_result[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.resp_valid, bus.resp_result[1], bus.req_ready} !== 36'd0) begin
            failures++; $display("FAIL rstmid_async got v=%b r=%h rdy=%b expected 0", bus.resp_valid, bus.resp_result[1], bus.req_ready);
        end
        bus.req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        bus.resp_ready = 2'b11;
        bus.req_op[0] = 5'h00; bus.req_a[0] = 32'd9; bus.req_b[0] = 32'd9;
        bus.req_valid = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rstmid_first_contended got=%b expected=01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rstmid_ptr_reset got=%b expected=01", bus.req_ready); end
        bus.req_valid = 2'b00;
        idle();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_illegal();
        test_imm();
        test_back_to_back();
        test_reset_mid();
        idle();
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            failures++; $display("FAIL sb_drain got=%0d/%0d pending expected=0/0", sb0.size(), sb1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
